// File: rtl/div_clk_checker.sv
// Period and duty checker for a divided clock sampled in its source clock domain.
module div_clk_checker #(
    parameter int unsigned DIV_RATIO  = 10,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             div_in,
    input  logic             en,
    input  logic             err_clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic             period_valid,
    output logic             locked,
    output logic             err
);

    localparam int unsigned GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  RATIO   = CNT_W'(DIV_RATIO);
    localparam logic [CNT_W-1:0]  TIMEOUT = CNT_W'(2 * DIV_RATIO);
    localparam logic [GOOD_W-1:0] LOCK_N  = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEEK    = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t            state, state_d;
    logic              div_q;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [CNT_W-1:0]  hcnt, hcnt_d;
    logic [GOOD_W-1:0] good_cnt, good_d;
    logic [GOOD_W-1:0] good_inc;
    logic [CNT_W-1:0]  period_d, high_d, low_d;
    logic              pv_d, locked_d, err_d, err_set;
    logic              rise, good;

    // Next state, counters and report values from the current sample of div_in.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        hcnt_d   = hcnt;
        good_d   = good_cnt;
        period_d = period;
        high_d   = high_len;
        low_d    = low_len;
        pv_d     = 1'b0;
        locked_d = locked;
        err_set  = 1'b0;
        rise     = div_in & ~div_q;
        good     = (cnt == RATIO);
        good_inc = good_cnt + GOOD_W'(1);

        if (!en) begin
            state_d  = IDLE;
            cnt_d    = '0;
            hcnt_d   = '0;
            good_d   = '0;
            locked_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = SEEK;
                end
                SEEK: begin
                    cnt_d  = '0;
                    hcnt_d = '0;
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_W'(1);
                        hcnt_d  = CNT_W'(1);
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise) begin
                        cnt_d    = CNT_W'(1);
                        hcnt_d   = CNT_W'(1);
                        period_d = cnt;
                        high_d   = hcnt;
                        low_d    = cnt - hcnt;
                        pv_d     = 1'b1;
                        if (good) begin
                            if (state == MEASURE) begin
                                good_d = good_inc;
                                if (good_inc == LOCK_N) begin
                                    state_d  = LOCKED;
                                    locked_d = 1'b1;
                                end
                            end
                        end else begin
                            good_d   = '0;
                            err_set  = 1'b1;
                            locked_d = 1'b0;
                            state_d  = MEASURE;
                        end
                    end else if (cnt == TIMEOUT) begin
                        // div_in stopped toggling: drop lock and re-acquire from scratch
                        err_set  = 1'b1;
                        locked_d = 1'b0;
                        state_d  = SEEK;
                        cnt_d    = '0;
                        hcnt_d   = '0;
                        good_d   = '0;
                    end else begin
                        if (cnt != CNT_MAX) begin
                            cnt_d = cnt + CNT_W'(1);
                        end
                        if (div_in && (hcnt != CNT_MAX)) begin
                            hcnt_d = hcnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // a new error wins over a simultaneous clear
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err);
    end

    // State, counters and all outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_q        <= 1'b0;
            cnt          <= '0;
            hcnt         <= '0;
            good_cnt     <= '0;
            period       <= '0;
            high_len     <= '0;
            low_len      <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_d;
            div_q        <= div_in;
            cnt          <= cnt_d;
            hcnt         <= hcnt_d;
            good_cnt     <= good_d;
            period       <= period_d;
            high_len     <= high_d;
            low_len      <= low_d;
            period_valid <= pv_d;
            locked       <= locked_d;
            err          <= err_d;
        end
    end

endmodule

// File: tb/tb_div_clk_checker.sv
// Bench for div_clk_checker: a div10 and a div5 instance against a timestamp model.
module tb_div_clk_checker;

    logic       clk;
    logic       rst_n;
    logic       div_s   [2];
    logic       en_s    [2];
    logic       clr_s   [2];
    logic [7:0] per_o   [2];
    logic [7:0] hi_o    [2];
    logic [7:0] lw_o    [2];
    logic       pv_o    [2];
    logic       lk_o    [2];
    logic       er_o    [2];

    int vectors = 0;
    int miscompares = 0;
    int pcnt    [2];
    int lock_at [2];
    int pbase;

    // model state: expected outputs plus period start timestamps
    int e_per [2], e_hi [2], e_lo [2];
    bit e_pv  [2], e_lk [2], e_err [2];
    int m_anchor [2], m_hcount [2], m_run [2];
    bit m_armed [2], m_prev [2];
    int m_t;
    bit m_rise, m_set;
    int m_len;

    div_clk_checker #(.DIV_RATIO(10), .CNT_W(8), .LOCK_COUNT(4)) u10 (
        .clk_in(clk), .rst_n(rst_n), .div_in(div_s[0]), .en(en_s[0]), .err_clr(clr_s[0]),
        .period(per_o[0]), .high_len(hi_o[0]), .low_len(lw_o[0]),
        .period_valid(pv_o[0]), .locked(lk_o[0]), .err(er_o[0])
    );

    div_clk_checker #(.DIV_RATIO(5), .CNT_W(8), .LOCK_COUNT(4)) u5 (
        .clk_in(clk), .rst_n(rst_n), .div_in(div_s[1]), .en(en_s[1]), .err_clr(clr_s[1]),
        .period(per_o[1]), .high_len(hi_o[1]), .low_len(lw_o[1]),
        .period_valid(pv_o[1]), .locked(lk_o[1]), .err(er_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ratio_of(input int i);
        return (i == 0) ? 10 : 5;
    endfunction

    // Model: a period is the distance between accepted rising samples of div_in.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                e_per[i] = 0; e_hi[i] = 0; e_lo[i] = 0;
                e_pv[i] = 0; e_lk[i] = 0; e_err[i] = 0;
                m_anchor[i] = -1; m_hcount[i] = 0; m_run[i] = 0;
                m_armed[i] = 0; m_prev[i] = 0;
            end
            m_t = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_rise = div_s[i] && !m_prev[i];
                m_set  = 0;
                e_pv[i] = 0;
                if (!en_s[i]) begin
                    m_armed[i] = 0; m_anchor[i] = -1; m_run[i] = 0; e_lk[i] = 0;
                end else if (!m_armed[i]) begin
                    m_armed[i] = 1;
                end else if (m_anchor[i] < 0) begin
                    if (m_rise) begin
                        m_anchor[i] = m_t; m_hcount[i] = 1;
                    end
                end else begin
                    m_len = m_t - m_anchor[i];
                    if (m_rise) begin
                        e_pv[i] = 1;
                        e_per[i] = m_len; e_hi[i] = m_hcount[i]; e_lo[i] = m_len - m_hcount[i];
                        if (m_len == ratio_of(i)) begin
                            m_run[i] = m_run[i] + 1;
                            if (m_run[i] >= 4) e_lk[i] = 1;
                        end else begin
                            m_run[i] = 0; e_lk[i] = 0; m_set = 1;
                        end
                        m_anchor[i] = m_t; m_hcount[i] = 1;
                    end else if (m_len == 2 * ratio_of(i)) begin
                        m_set = 1; e_lk[i] = 0; m_anchor[i] = -1; m_run[i] = 0;
                    end else if (div_s[i]) begin
                        m_hcount[i] = m_hcount[i] + 1;
                    end
                end
                e_err[i] = m_set ? 1'b1 : (clr_s[i] ? 1'b0 : e_err[i]);
                m_prev[i] = div_s[i];
            end
            m_t = m_t + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare both instances with the model.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.period", i),   int'(per_o[i]), e_per[i]);
            chk($sformatf("u%0d.high_len", i), int'(hi_o[i]),  e_hi[i]);
            chk($sformatf("u%0d.low_len", i),  int'(lw_o[i]),  e_lo[i]);
            chk($sformatf("u%0d.pv", i),       int'(pv_o[i]),  int'(e_pv[i]));
            chk($sformatf("u%0d.locked", i),   int'(lk_o[i]),  int'(e_lk[i]));
            chk($sformatf("u%0d.err", i),      int'(er_o[i]),  int'(e_err[i]));
            pcnt[i] = pcnt[i] + int'(pv_o[i]);
            if (lk_o[i] && lock_at[i] == 0) lock_at[i] = pcnt[i];
        end
    endtask

    task automatic drive(input int idx, input logic v, input int n);
        for (int k = 0; k < n; k++) begin
            div_s[idx] = v;
            tick();
        end
    endtask

    task automatic wave(input int idx, input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            drive(idx, 1'b1, hi);
            drive(idx, 1'b0, lo);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            div_s[i] = 1'b0; en_s[i] = 1'b0; clr_s[i] = 1'b0;
            pcnt[i] = 0; lock_at[i] = 0;
        end
        tick(); tick();
        chk("rst.period", int'(per_o[0]), 0);
        chk("rst.locked", int'(lk_o[0]), 0);
        chk("rst.err", int'(er_o[0]), 0);
        rst_n = 1'b1;
        tick();

        // div10, 5 high / 5 low
        en_s[0] = 1'b1;
        drive(0, 1'b0, 2);
        pbase = pcnt[0];
        wave(0, 5, 5, 6);
        chk("t1.pulses", pcnt[0] - pbase, 5);
        chk("t1.lock_pulse", lock_at[0], 4);
        chk("t1.period", int'(per_o[0]), 10);
        chk("t1.high", int'(hi_o[0]), 5);
        chk("t1.low", int'(lw_o[0]), 5);
        chk("t1.locked", int'(lk_o[0]), 1);
        chk("t1.err", int'(er_o[0]), 0);

        // one 11-cycle period while locked
        wave(0, 6, 5, 1);
        drive(0, 1'b1, 1);
        chk("t3.pv", int'(pv_o[0]), 1);
        chk("t3.period", int'(per_o[0]), 11);
        chk("t3.err", int'(er_o[0]), 1);
        chk("t3.locked", int'(lk_o[0]), 0);
        drive(0, 1'b1, 4);
        drive(0, 1'b0, 5);
        wave(0, 5, 5, 4);
        chk("t3.relock", int'(lk_o[0]), 1);
        chk("t3.err_sticky", int'(er_o[0]), 1);

        // err_clr alone, then err_clr on the same edge as a bad period
        clr_s[0] = 1'b1;
        drive(0, 1'b1, 1);
        clr_s[0] = 1'b0;
        drive(0, 1'b1, 4);
        drive(0, 1'b0, 5);
        chk("t6.cleared", int'(er_o[0]), 0);
        drive(0, 1'b1, 4);
        drive(0, 1'b0, 5);
        clr_s[0] = 1'b1;
        drive(0, 1'b1, 1);
        chk("t6.bad_pv", int'(pv_o[0]), 1);
        chk("t6.bad_period", int'(per_o[0]), 9);
        chk("t6.set_wins", int'(er_o[0]), 1);
        drive(0, 1'b1, 1);
        chk("t6.clr_alone", int'(er_o[0]), 0);
        clr_s[0] = 1'b0;
        drive(0, 1'b1, 3);
        drive(0, 1'b0, 5);

        // timeout while locked, then resume
        wave(0, 5, 5, 4);
        chk("t4.locked", int'(lk_o[0]), 1);
        drive(0, 1'b1, 5);
        drive(0, 1'b0, 15);
        chk("t4.pre_err", int'(er_o[0]), 0);
        chk("t4.pre_locked", int'(lk_o[0]), 1);
        drive(0, 1'b0, 1);
        chk("t4.to_err", int'(er_o[0]), 1);
        chk("t4.to_locked", int'(lk_o[0]), 0);
        chk("t4.to_pv", int'(pv_o[0]), 0);
        drive(0, 1'b0, 5);
        pbase = pcnt[0];
        wave(0, 5, 5, 3);
        chk("t4.resume_pulses", pcnt[0] - pbase, 2);

        // disable while locked with err set, then async reset mid-period
        wave(0, 5, 5, 3);
        chk("t5.locked", int'(lk_o[0]), 1);
        chk("t5.err", int'(er_o[0]), 1);
        en_s[0] = 1'b0;
        drive(0, 1'b0, 1);
        chk("t5.en_locked", int'(lk_o[0]), 0);
        chk("t5.en_err", int'(er_o[0]), 1);
        chk("t5.en_period", int'(per_o[0]), 10);
        en_s[0] = 1'b1;
        drive(0, 1'b0, 2);
        wave(0, 5, 5, 3);
        drive(0, 1'b1, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5.rst_period", int'(per_o[0]), 0);
        chk("t5.rst_high", int'(hi_o[0]), 0);
        chk("t5.rst_low", int'(lw_o[0]), 0);
        chk("t5.rst_err", int'(er_o[0]), 0);
        chk("t5.rst_locked", int'(lk_o[0]), 0);
        tick(); tick();
        rst_n = 1'b1;
        drive(0, 1'b0, 2);
        en_s[0] = 1'b0;

        // div5, 2 high / 3 low
        en_s[1] = 1'b1;
        drive(1, 1'b0, 2);
        pbase = pcnt[1];
        wave(1, 2, 3, 6);
        chk("t2.pulses", pcnt[1] - pbase, 5);
        chk("t2.lock_pulse", lock_at[1], 4);
        chk("t2.period", int'(per_o[1]), 5);
        chk("t2.high", int'(hi_o[1]), 2);
        chk("t2.low", int'(lw_o[1]), 3);
        chk("t2.locked", int'(lk_o[1]), 1);
        chk("t2.err", int'(er_o[1]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
